// File: rtl/mult_div_unit_if.sv
// Operation/result bundle between the EX-stage issue logic and mult_div_unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] Operand_A;
   logic [WIDTH-1:0] Operand_B;
   logic             Flush;
   logic             Hi_Write;
   logic             Lo_Write;
   logic [WIDTH-1:0] Write_Data;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic             Busy;
   logic             Done;
   logic             Div_By_Zero;
   logic             Stall_Request;

   modport master (
      output Start, Op, Operand_A, Operand_B, Flush, Hi_Write, Lo_Write, Write_Data,
      input  HI, LO, Busy, Done, Div_By_Zero, Stall_Request
   );

   modport slave (
      input  Start, Op, Operand_A, Operand_B, Flush, Hi_Write, Lo_Write, Write_Data,
      output HI, LO, Busy, Done, Div_By_Zero, Stall_Request
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS32 MULT/MULTU/DIV/DIVU unit owning HI/LO; one shift step per cycle.
// Optional zero-operand early out is enabled by defining MULDIV_EARLY_OUT_EN.
module mult_div_unit #(
   parameter int WIDTH    = 32,
   parameter int CNT_BITS = 6
) (
   input  logic          Clk,
   input  logic          Reset,
   mult_div_unit_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   state_e                state_q, state_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   // Upper half: partial product / remainder; lower half: multiplier / quotient.
   logic [2*WIDTH-1:0]    prod_q, prod_d;
   logic [WIDTH-1:0]      addend_q, addend_d;
   logic                  is_div_q, is_div_d;
   logic                  neg_q, neg_d;
   logic                  neg_rem_q, neg_rem_d;
   logic                  dbz_q, dbz_d;
   logic                  busy_q, busy_d;
   logic [WIDTH-1:0]      hi_q, hi_d;
   logic [WIDTH-1:0]      lo_q, lo_d;

   logic                  op_signed, sign_a, sign_b, op_div;
   logic [WIDTH-1:0]      mag_a, mag_b;
   logic [WIDTH:0]        mul_sum, rem_sh, rem_diff;
   logic [2*WIDTH-1:0]    prod_fix;
   logic [WIDTH-1:0]      quo_fix, rem_fix;

   assign op_div    = bus.Op[1];
   assign op_signed = ~bus.Op[0];
   assign sign_a    = op_signed & bus.Operand_A[WIDTH-1];
   assign sign_b    = op_signed & bus.Operand_B[WIDTH-1];
   assign mag_a     = sign_a ? -bus.Operand_A : bus.Operand_A;
   assign mag_b     = sign_b ? -bus.Operand_B : bus.Operand_B;

   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? addend_q : '0)};
   assign rem_sh   = prod_q[2*WIDTH-1:WIDTH-1];
   assign rem_diff = rem_sh - {1'b0, addend_q};

   assign prod_fix = neg_q ? -prod_q : prod_q;
   assign quo_fix  = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
   assign rem_fix  = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

   always_comb begin
      // NOTE: every next-state value gets a default first so no path infers a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      addend_d  = addend_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      busy_d    = busy_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      if (bus.Flush) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.Hi_Write) hi_d = bus.Write_Data;
               if (bus.Lo_Write) lo_d = bus.Write_Data;
               if (bus.Start) begin
                  is_div_d  = op_div;
                  neg_d     = sign_a ^ sign_b;
                  neg_rem_d = sign_a;
                  dbz_d     = op_div & (bus.Operand_B == '0);
                  prod_d    = {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
                  addend_d  = op_div ? mag_b : mag_a;
                  cnt_d     = CNT_BITS'(WIDTH - 1);
                  busy_d    = 1'b1;
                  state_d   = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                  // A zeroed accumulator makes FIX produce the zero result (and the
                  // divide-by-zero override) while keeping the two-cycle latency.
                  if ((bus.Operand_A == '0) || (!op_div && (bus.Operand_B == '0))) begin
                     prod_d  = '0;
                     state_d = S_FIX;
                  end
`endif
               end
            end
            S_CALC: begin
               if (is_div_q) begin
                  if (!rem_diff[WIDTH]) prod_d = {rem_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                  else                  prod_d = {rem_sh[WIDTH-1:0],   prod_q[WIDTH-2:0], 1'b0};
               end else begin
                  prod_d = {mul_sum, prod_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = dbz_q ? '1 : quo_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
               busy_d  = 1'b0;
               state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (Reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         prod_q    <= '0;
         addend_q  <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         prod_q    <= prod_d;
         addend_q  <= addend_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         busy_q    <= busy_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign bus.HI            = hi_q;
   assign bus.LO            = lo_q;
   assign bus.Busy          = busy_q;
   assign bus.Done          = (state_q == S_DONE);
   assign bus.Div_By_Zero   = (state_q == S_DONE) & dbz_q;
   assign bus.Stall_Request = busy_q | (bus.Start & (state_q == S_IDLE));

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, monitor checks each Done.
module tb_mult_div_unit;
   localparam int W = 32;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   mult_div_unit_if #(.WIDTH(W)) bus ();
   mult_div_unit #(.WIDTH(W), .CNT_BITS(6)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           launch;
      int           lat;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;
   int   cyc     = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every Done pulse must match the oldest outstanding expectation.
   always @(negedge Clk) begin
      if (Reset === 1'b0 && bus.Done === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious Done", {63'd0, bus.Done}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, " HI"},      bus.HI, e.hi);
            check({e.name, " LO"},      bus.LO, e.lo);
            check({e.name, " DBZ"},     bus.Div_By_Zero, e.dbz);
            check({e.name, " latency"}, cyc - e.launch, e.lat);
         end
      end
   end

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   function automatic int lat_of(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (a == '0 || (!op[1] && b == '0)) return 2;
`endif
      return W + 2;
   endfunction

   task automatic launch(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                         input logic dbz);
      exp_t e;
      bus.Start = 1'b1; bus.Op = op; bus.Operand_A = a; bus.Operand_B = b;
      e.hi = hi; e.lo = lo; e.dbz = dbz; e.launch = cyc; e.lat = lat_of(op, a, b); e.name = name;
      sb.push_back(e);
      tick();
      bus.Start = 1'b0;
      bus.Operand_A = $urandom;
      bus.Operand_B = $urandom;
      check({name, " Busy after launch"}, {63'd0, bus.Busy}, 64'd1);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
      check({name, " completes in budget"}, sb.size(), 64'd0);
      sb.delete();
      tick();
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo,
                         input logic dbz);
      launch(name, op, a, b, hi, lo, dbz);
      wait_done(name);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      Reset = 1'b1;
      bus.Start = 1'b0; bus.Op = 2'b00; bus.Operand_A = '0; bus.Operand_B = '0;
      bus.Flush = 1'b0; bus.Hi_Write = 1'b0; bus.Lo_Write = 1'b0; bus.Write_Data = '0;
      repeat (3) tick();
      Reset = 1'b0;
      check("reset HI",   bus.HI, 64'd0);
      check("reset LO",   bus.LO, 64'd0);
      check("reset Busy", {63'd0, bus.Busy}, 64'd0);
      check("reset Done", {63'd0, bus.Done}, 64'd0);
      check("reset DBZ",  {63'd0, bus.Div_By_Zero}, 64'd0);
      check("reset Stall", {63'd0, bus.Stall_Request}, 64'd0);
      tick();

      run_op("MULT -3*7",      2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      run_op("MULTU max*max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run_op("MULT min*min",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      run_op("MULT maxpos*-1", 2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0);
      run_op("MULTU x*16",     2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0);
      run_op("MULT 0*5",       2'b00, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0);
      run_op("DIV -7/2",       2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op("DIV 7/-2",       2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      run_op("DIVU 100/7",     2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
      run_op("DIVU x/0",       2'b11, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1'b1);
      run_op("DIV -5/0",       2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
      run_op("DIVU 0/0",       2'b11, 32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1);
      run_op("DIV ovf",        2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);

      // Flush mid-CALC with Start held: no Done, HI/LO kept, relaunch next cycle.
      begin
         int n;
         exp_t e;
         bus.Start = 1'b1; bus.Op = 2'b00; bus.Operand_A = 32'd5; bus.Operand_B = 32'd6;
         n = cyc;
         repeat (10) tick();
         bus.Flush = 1'b1;
         tick();
         bus.Flush = 1'b0;
         check("flush cycle index",   cyc - n, 64'd11);
         check("flush Busy low",      {63'd0, bus.Busy}, 64'd0);
         check("flush HI unchanged",  bus.HI, 64'd0);
         check("flush LO unchanged",  bus.LO, 64'h80000000);
         check("flush Stall w/Start", {63'd0, bus.Stall_Request}, 64'd1);
         e.hi = 32'd0; e.lo = 32'd30; e.dbz = 1'b0; e.launch = cyc; e.lat = W + 2; e.name = "relaunch 5*6";
         sb.push_back(e);
         tick();
         bus.Start = 1'b0;
         wait_done("relaunch 5*6");
      end

      // Start and Lo_Write while busy are ignored; Hi/Lo writes land in IDLE.
      launch("DIVU 100/7 b", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      repeat (3) tick();
      bus.Start = 1'b1; bus.Op = 2'b01; bus.Operand_A = 32'd9; bus.Operand_B = 32'd3;
      check("busy Stall_Request", {63'd0, bus.Stall_Request}, 64'd1);
      tick();
      bus.Start = 1'b0;
      bus.Lo_Write = 1'b1; bus.Write_Data = 32'hA5A5A5A5;
      tick();
      bus.Lo_Write = 1'b0;
      check("busy Lo_Write ignored", bus.LO, 64'd30);
      wait_done("DIVU 100/7 b");
      bus.Lo_Write = 1'b1; bus.Write_Data = 32'hA5A5A5A5;
      tick();
      bus.Lo_Write = 1'b0;
      check("idle Lo_Write LO", bus.LO, 64'hA5A5A5A5);
      check("idle Lo_Write HI", bus.HI, 64'd2);
      bus.Hi_Write = 1'b1; bus.Write_Data = 32'h5A5A5A5A;
      tick();
      bus.Hi_Write = 1'b0;
      check("idle Hi_Write HI", bus.HI, 64'h5A5A5A5A);

      // Reset mid-CALC clears HI/LO and Busy on the next cycle.
      bus.Start = 1'b1; bus.Op = 2'b01; bus.Operand_A = 32'hFFFFFFFF; bus.Operand_B = 32'hFFFFFFFF;
      tick();
      bus.Start = 1'b0;
      repeat (5) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("midreset HI",   bus.HI, 64'd0);
      check("midreset LO",   bus.LO, 64'd0);
      check("midreset Busy", {63'd0, bus.Busy}, 64'd0);
      tick();

      run_op("post-reset MULTU", 2'b01, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
